dpr_w_i_ctrl: RTL and testbench
===============================

DPR_W_I_CTRL -- requirements
Module: dpr_w_i_ctrl

Interface
REQ-001 Parameter FEATURE_BITS, default 4, width of feature/gamma counts.
REQ-002 Parameter ELEMENT_BITS, default 8, width of one weight element.
REQ-003 sys_clk  in  1  single clock; all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 m  in  FEATURE_BITS  feature count (sampled at load_start).
REQ-006 gamma  in  FEATURE_BITS  column count (sampled at load_start).
REQ-007 clear  in  1  synchronous abort to IDLE.
REQ-008 load_start  in  1  one-cycle pulse; begin weight load.
REQ-009 wr_valid / wr_data  in  1 / ELEMENT_BITS  incoming weight stream.
REQ-010 wr_ready  out  1  controller accepts wr_data this cycle.
REQ-011 rd_start  in  1  one-cycle pulse; begin weight readout.
REQ-012 rd_ready  in  1  downstream (systolic array) can take an element.
REQ-013 cs_in, we_in  out  1 each  DPR write-port chip select / write enable.
REQ-014 address_in  out  2*FEATURE_BITS  DPR write address.
REQ-015 data_in  out  ELEMENT_BITS  DPR write data.
REQ-016 cs_out, oe_out  out  1 each  DPR read-port chip select / output enable.
REQ-017 address_out  out  2*FEATURE_BITS  DPR read address.
REQ-018 rd_valid  out  1  DPR data_out valid this cycle.
REQ-019 busy, load_done, rd_done, err  out  1 each  status; done/err are one-cycle pulses.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, READY, READ; busy = (LOAD or READ).
REQ-021 depth SHALL be m*gamma, computed at full 2*FEATURE_BITS width (no truncation), latched at load_start.
REQ-022 load_start in IDLE or READY with depth!=0 SHALL go to LOAD, wr_cnt=0; with depth==0 SHALL stay, pulse err.
REQ-023 LOAD: wr_ready=1; each wr_valid&wr_ready handshake SHALL register cs_in=we_in=1, address_in=wr_cnt, data_in=wr_data next cycle, then wr_cnt++.
REQ-024 No handshake in a LOAD cycle SHALL give cs_in=we_in=0 next cycle; address_in/data_in hold.
REQ-025 Handshake with wr_cnt==depth-1 SHALL go to READY and pulse load_done coincident with the last write strobe; wr_ready=0 from that cycle.
REQ-026 rd_start in READY SHALL go to READ, rd_cnt=0; rd_start in IDLE, LOAD or READ SHALL be ignored, pulse err.
REQ-027 READ: each cycle with rd_ready=1 SHALL register cs_out=oe_out=1, address_out=rd_cnt next cycle, then rd_cnt++; rd_ready=0 SHALL give cs_out=oe_out=0, address_out held.
REQ-028 rd_valid SHALL assert exactly one cycle after each issued read strobe (DPR read latency 1).
REQ-029 After issuing address depth-1, SHALL return to READY; rd_done SHALL pulse coincident with the last rd_valid.
REQ-030 READY SHALL retain weights; repeated rd_start SHALL replay the full sweep without reload.
REQ-031 load_start during LOAD or READ SHALL be ignored, pulse err.
REQ-032 clear SHALL go to IDLE next cycle, deassert all strobes, zero counters, drop pending rd_valid/done; clear has priority over every start.
REQ-033 Simultaneous load_start and rd_start in READY: load_start wins, rd_start flagged err.
REQ-034 Addresses SHALL never exceed depth-1; no wrap-around within a sweep.

Reset
REQ-035 reset_n low SHALL asynchronously force IDLE, counters 0, all outputs 0 (address/data buses included).
REQ-036 Reset mid-LOAD or mid-READ SHALL abandon the operation; READY reachable only by a new complete load.

Verification
REQ-037 m=9, gamma=3, load_start, 27 back-to-back wr_valid with random data -> address_in 0..26 strobed, load_done with address 26, state READY.
REQ-038 Same load with wr_valid deasserted every third cycle -> no strobe during gaps, addresses contiguous, exactly 27 writes.
REQ-039 rd_start, rd_ready toggling 1/0 -> address_out 0..26 in order, rd_valid one cycle after each strobe, rd_done with 27th rd_valid; data matches written.
REQ-040 m=0, gamma=3 load_start -> err pulse, remains IDLE; then rd_start -> err pulse, no cs_out.
REQ-041 m=15, gamma=15 -> depth 225, final address_in 224 (no truncation).
REQ-042 reset_n low at read address 10 -> outputs 0 immediately; rd_start after release -> err, no strobe.

Source files
------------

// File: rtl/dpr_w_i_ctrl.sv
// Weight-load / weight-readout controller for a dual-port RAM feeding a systolic array.
// The write port is filled from a valid/ready stream; the read port is swept under rd_ready backpressure.
module dpr_w_i_ctrl #(
  parameter int FEATURE_BITS = 4,
  parameter int ELEMENT_BITS = 8
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  input  logic [FEATURE_BITS-1:0]   m,
  input  logic [FEATURE_BITS-1:0]   gamma,
  input  logic                      clear,
  input  logic                      load_start,
  input  logic                      wr_valid,
  input  logic [ELEMENT_BITS-1:0]   wr_data,
  output logic                      wr_ready,
  input  logic                      rd_start,
  input  logic                      rd_ready,
  output logic                      cs_in,
  output logic                      we_in,
  output logic [2*FEATURE_BITS-1:0] address_in,
  output logic [ELEMENT_BITS-1:0]   data_in,
  output logic                      cs_out,
  output logic                      oe_out,
  output logic [2*FEATURE_BITS-1:0] address_out,
  output logic                      rd_valid,
  output logic                      busy,
  output logic                      load_done,
  output logic                      rd_done,
  output logic                      err
);

  localparam int AW = 2 * FEATURE_BITS;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_READ} state_t;

  state_t                  r_state, w_state_nxt;
  logic [AW-1:0]           r_depth, r_wr_cnt, r_rd_cnt;
  logic                    r_cs_in, r_we_in, r_cs_out, r_oe_out;
  logic [AW-1:0]           r_address_in, r_address_out;
  logic [ELEMENT_BITS-1:0] r_data_in;
  logic                    r_rd_valid, r_rd_last, r_rd_done, r_load_done, r_err;

  logic [AW-1:0] w_depth_new;
  logic          w_load_go, w_wr_hs, w_wr_last, w_rd_go, w_rd_issue, w_rd_last, w_err;

  // Product formed at full 2*FEATURE_BITS width so 15x15 yields 225, not a truncated value.
  assign w_depth_new = AW'(m) * AW'(gamma);
  assign w_load_go   = load_start && (w_depth_new != '0) &&
                       ((r_state == S_IDLE) || (r_state == S_READY));
  assign w_wr_hs     = (r_state == S_LOAD) && wr_valid;
  assign w_wr_last   = w_wr_hs && (r_wr_cnt == r_depth - AW'(1));
  // load_start outranks rd_start in READY; the losing rd_start is reported as an error.
  assign w_rd_go     = rd_start && !load_start && (r_state == S_READY);
  assign w_rd_issue  = (r_state == S_READ) && rd_ready;
  assign w_rd_last   = w_rd_issue && (r_rd_cnt == r_depth - AW'(1));
  assign w_err       = !clear && ((load_start && !w_load_go) || (rd_start && !w_rd_go));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: default assignment first so no path leaves w_state_nxt unassigned (avoids a latch).
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_load_go) w_state_nxt = S_LOAD;
        S_LOAD:  if (w_wr_last) w_state_nxt = S_READY;
        S_READY: begin
          if (w_load_go)    w_state_nxt = S_LOAD;
          else if (w_rd_go) w_state_nxt = S_READ;
        end
        S_READ:  if (w_rd_last) w_state_nxt = S_READY;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ready = (r_state == S_LOAD);
    busy     = (r_state == S_LOAD) || (r_state == S_READ);
  end

  // NOTE: only control/datapath flops are reset here; the weight storage itself lives in the external DPR.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_depth       <= '0;
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_cs_in       <= 1'b0;
      r_we_in       <= 1'b0;
      r_address_in  <= '0;
      r_data_in     <= '0;
      r_cs_out      <= 1'b0;
      r_oe_out      <= 1'b0;
      r_address_out <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_last     <= 1'b0;
      r_rd_done     <= 1'b0;
      r_load_done   <= 1'b0;
      r_err         <= 1'b0;
    end else if (clear) begin
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_cs_in     <= 1'b0;
      r_we_in     <= 1'b0;
      r_cs_out    <= 1'b0;
      r_oe_out    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_done   <= 1'b0;
      r_load_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cs_in     <= w_wr_hs;
      r_we_in     <= w_wr_hs;
      r_cs_out    <= w_rd_issue;
      r_oe_out    <= w_rd_issue;
      r_load_done <= w_wr_last;
      r_err       <= w_err;
      // DPR read latency is one cycle: valid/done trail the read strobe by one register.
      r_rd_valid  <= r_cs_out;
      r_rd_last   <= w_rd_last;
      r_rd_done   <= r_rd_last;

      if (w_load_go) begin
        r_depth  <= w_depth_new;
        r_wr_cnt <= '0;
      end
      if (w_wr_hs) begin
        r_address_in <= r_wr_cnt;
        r_data_in    <= wr_data;
        r_wr_cnt     <= r_wr_cnt + AW'(1);
      end
      if (w_rd_go) r_rd_cnt <= '0;
      if (w_rd_issue) begin
        r_address_out <= r_rd_cnt;
        r_rd_cnt      <= r_rd_cnt + AW'(1);
      end
    end
  end

  assign cs_in       = r_cs_in;
  assign we_in       = r_we_in;
  assign address_in  = r_address_in;
  assign data_in     = r_data_in;
  assign cs_out      = r_cs_out;
  assign oe_out      = r_oe_out;
  assign address_out = r_address_out;
  assign rd_valid    = r_rd_valid;
  assign rd_done     = r_rd_done;
  assign load_done   = r_load_done;
  assign err         = r_err;

endmodule

// File: tb/tb_dpr_w_i_ctrl.sv
// Directed bench for dpr_w_i_ctrl with a behavioural 1-cycle-latency DPR model behind it.
module tb_dpr_w_i_ctrl;

  localparam int FB = 4;
  localparam int EB = 8;
  localparam int AW = 2 * FB;

  logic          sys_clk = 1'b0;
  logic          reset_n;
  logic [FB-1:0] m, gamma;
  logic          clear, load_start, wr_valid, rd_start, rd_ready;
  logic [EB-1:0] wr_data;
  logic          wr_ready, cs_in, we_in, cs_out, oe_out, rd_valid;
  logic          busy, load_done, rd_done, err;
  logic [AW-1:0] address_in, address_out;
  logic [EB-1:0] data_in;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EB-1:0] exp_data [256];
  logic [EB-1:0] dpr_mem  [256];
  logic [EB-1:0] dpr_q;

  always #5 sys_clk = ~sys_clk;

  dpr_w_i_ctrl #(.FEATURE_BITS(FB), .ELEMENT_BITS(EB)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .m(m), .gamma(gamma), .clear(clear),
    .load_start(load_start), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_start(rd_start), .rd_ready(rd_ready), .cs_in(cs_in), .we_in(we_in),
    .address_in(address_in), .data_in(data_in), .cs_out(cs_out), .oe_out(oe_out),
    .address_out(address_out), .rd_valid(rd_valid), .busy(busy), .load_done(load_done),
    .rd_done(rd_done), .err(err)
  );

  // Dual-port RAM: synchronous write, registered read.
  always @(posedge sys_clk) begin
    if (cs_in && we_in)   dpr_mem[address_in] <= data_in;
    if (cs_out && oe_out) dpr_q <= dpr_mem[address_out];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {30'd0, wr_ready, cs_in, we_in, address_in, data_in, cs_out, oe_out,
            address_out, rd_valid, busy, load_done, rd_done, err};
  endfunction

  task automatic do_load(input int mm, input int gg, input bit gap);
    int depth, idx, cyc;
    bit v;
    depth = mm * gg;
    @(negedge sys_clk);
    m = FB'(mm); gamma = FB'(gg); load_start = 1'b1;
    @(negedge sys_clk);
    load_start = 1'b0;
    check("ld_busy", busy, 1);
    check("ld_wr_ready", wr_ready, 1);
    idx = 0; cyc = 0;
    while (idx < depth && cyc < 2 * depth + 10) begin
      v = !(gap && (cyc % 3 == 2));
      wr_valid = v;
      wr_data  = EB'($urandom);
      if (v) exp_data[idx] = wr_data;
      @(negedge sys_clk);
      check("ld_cs_in", cs_in, v);
      check("ld_we_in", we_in, v);
      if (v) begin
        check("ld_addr", address_in, idx);
        check("ld_data", data_in, exp_data[idx]);
        check("ld_done", load_done, (idx == depth - 1));
        idx++;
      end else begin
        check("ld_gap_done", load_done, 0);
        if (idx > 0) check("ld_gap_addr_hold", address_in, idx - 1);
      end
      cyc++;
    end
    wr_valid = 1'b0;
    check("ld_writes", idx, depth);
    check("ld_ready_busy", busy, 0);
    check("ld_ready_wr_ready", wr_ready, 0);
    @(negedge sys_clk);
    check("ld_no_extra_write", cs_in, 0);
  endtask

  task automatic do_read(input int depth);
    int issued, seen, cyc;
    bit r, prev_strobe, prev_last;
    @(negedge sys_clk);
    rd_start = 1'b1;
    @(negedge sys_clk);
    rd_start = 1'b0;
    check("rd_busy", busy, 1);
    issued = 0; seen = 0; cyc = 0; prev_strobe = 0; prev_last = 0;
    while (seen < depth && cyc < 4 * depth + 10) begin
      r = (issued < depth) && (cyc % 2 == 0);
      rd_ready = r;
      @(negedge sys_clk);
      check("rd_cs_out", cs_out, r);
      check("rd_oe_out", oe_out, r);
      if (r) check("rd_addr", address_out, issued);
      check("rd_valid", rd_valid, prev_strobe);
      check("rd_done", rd_done, prev_last);
      if (prev_strobe) begin
        check("rd_data", dpr_q, exp_data[seen]);
        seen++;
      end
      prev_last   = r && (issued == depth - 1);
      prev_strobe = r;
      if (r) issued++;
      cyc++;
    end
    rd_ready = 1'b0;
    check("rd_count", seen, depth);
    check("rd_back_to_ready", busy, 0);
  endtask

  initial begin
    bit found;
    reset_n = 1'b0; m = '0; gamma = '0; clear = 1'b0; load_start = 1'b0;
    wr_valid = 1'b0; wr_data = '0; rd_start = 1'b0; rd_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("reset_outs", all_outs(), 64'd0);
    reset_n = 1'b1;

    // Zero depth: load rejected, then read rejected from IDLE.
    @(negedge sys_clk);
    m = 4'd0; gamma = 4'd3; load_start = 1'b1;
    @(negedge sys_clk);
    load_start = 1'b0;
    check("zero_depth_err", err, 1);
    check("zero_depth_idle", busy, 0);
    check("zero_depth_wr_ready", wr_ready, 0);
    rd_start = 1'b1;
    @(negedge sys_clk);
    rd_start = 1'b0;
    check("idle_rd_err", err, 1);
    check("idle_rd_no_cs", cs_out, 0);
    @(negedge sys_clk);
    check("idle_rd_err_pulse", err, 0);
    check("idle_rd_still_no_cs", cs_out, 0);

    do_load(9, 3, 1'b0);
    do_read(27);
    do_read(27);
    do_load(9, 3, 1'b1);
    do_read(27);

    // load_start and rd_start together in READY, then load_start in LOAD, then clear.
    @(negedge sys_clk);
    m = 4'd9; gamma = 4'd3; load_start = 1'b1; rd_start = 1'b1;
    @(negedge sys_clk);
    load_start = 1'b0; rd_start = 1'b0;
    check("both_start_err", err, 1);
    check("both_start_load", wr_ready, 1);
    load_start = 1'b1;
    @(negedge sys_clk);
    load_start = 1'b0;
    check("load_in_load_err", err, 1);
    check("load_in_load_busy", busy, 1);
    clear = 1'b1;
    @(negedge sys_clk);
    clear = 1'b0;
    check("clear_idle", busy, 0);
    check("clear_wr_ready", wr_ready, 0);
    check("clear_no_err", err, 0);
    rd_start = 1'b1;
    @(negedge sys_clk);
    rd_start = 1'b0;
    check("after_clear_rd_err", err, 1);
    check("after_clear_no_cs", cs_out, 0);

    do_load(15, 15, 1'b0);

    // Reset in the middle of a read sweep.
    do_load(9, 3, 1'b0);
    @(negedge sys_clk);
    rd_start = 1'b1;
    @(negedge sys_clk);
    rd_start = 1'b0;
    rd_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge sys_clk);
      if (cs_out && address_out == AW'(10)) found = 1'b1;
    end
    check("mid_read_reach_10", found, 1);
    #2 reset_n = 1'b0;
    #1 check("mid_read_reset_outs", all_outs(), 64'd0);
    @(negedge sys_clk);
    reset_n = 1'b1;
    @(negedge sys_clk);
    rd_start = 1'b1;
    @(negedge sys_clk);
    rd_start = 1'b0;
    check("post_reset_rd_err", err, 1);
    check("post_reset_no_cs", cs_out, 0);
    @(negedge sys_clk);
    check("post_reset_still_no_cs", cs_out, 0);
    check("post_reset_idle", busy, 0);
    rd_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
